// File: rtl/next_pc_pkg.sv
// Shared definitions for the next-PC unit and the control unit that sequences it.
// Phase numbering constants live here so both sides agree on when results are captured.
package next_pc_pkg;

  typedef enum logic [1:0] {
    MODE_SEQ    = 2'b00,
    MODE_BRANCH = 2'b01,
    MODE_JAL    = 2'b10,
    MODE_JALR   = 2'b11
  } mode_t;

  localparam int DEFAULT_XLEN       = 32;
  localparam int DEFAULT_NUM_PHASES = 10;
  localparam int DEFAULT_CALC_PHASE = 4;

endpackage

// File: rtl/next_pc_unit_if.sv
// Bundle between the datapath/control and the next-PC unit.
// master drives operands and stall; slave is the next-PC unit itself.
interface next_pc_unit_if
  import next_pc_pkg::*;
#(
  parameter int XLEN       = DEFAULT_XLEN,
  parameter int NUM_PHASES = DEFAULT_NUM_PHASES
);
  localparam int PW = $clog2(NUM_PHASES);

  logic            enable;
  logic [XLEN-1:0] pc_in;
  logic [XLEN-1:0] rs1_in;
  logic [XLEN-1:0] imm_in;
  mode_t           mode_in;
  logic            taken_in;
  logic [PW-1:0]   phase_out;
  logic [XLEN-1:0] target_out;
  logic [XLEN-1:0] link_out;
  logic [XLEN-1:0] next_pc_out;
  logic            valid_out;
  logic            misaligned_out;

  modport master (
    output enable, pc_in, rs1_in, imm_in, mode_in, taken_in,
    input  phase_out, target_out, link_out, next_pc_out, valid_out, misaligned_out
  );

  modport slave (
    input  enable, pc_in, rs1_in, imm_in, mode_in, taken_in,
    output phase_out, target_out, link_out, next_pc_out, valid_out, misaligned_out
  );
endinterface

// File: rtl/next_pc_unit_phase_counter.sv
// Per-instruction phase counter, modulo NUM_PHASES, with a compare strobe for one phase.
// Latency: phase advances one edge after enable; at_phase is combinational from phase.
// Backpressure: enable=0 freezes the count.
module phase_counter #(
  parameter int NUM_PHASES = 10,
  parameter int AT_PHASE   = 0,
  parameter int PW         = $clog2(NUM_PHASES)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  output logic [PW-1:0] phase,
  output logic          at_phase
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase <= '0;
    end else if (enable) begin
      phase <= (phase == PW'(NUM_PHASES - 1)) ? '0 : phase + PW'(1);
    end
  end

  assign at_phase = (phase == PW'(AT_PHASE));

endmodule

// File: rtl/next_pc_unit.sv
// Branch/jump target, link address and next-PC select, captured once per instruction.
// Latency: 1 clock from the capture edge to registered results and the valid pulse.
// Backpressure: enable=0 stalls the phase and defers capture until the next enabled edge.
module next_pc_unit
  import next_pc_pkg::*;
#(
  parameter int XLEN       = DEFAULT_XLEN,
  parameter int NUM_PHASES = DEFAULT_NUM_PHASES,
  parameter int CALC_PHASE = DEFAULT_CALC_PHASE,
  parameter int WORD_ADDR  = 1,
  parameter int PC_STEP    = 1
) (
  input  logic           clock,
  input  logic           reset,
  next_pc_unit_if.slave  bus
);

  localparam int PW = $clog2(NUM_PHASES);
  localparam bit BYTE_ADDR = (WORD_ADDR == 0);

  if (CALC_PHASE >= NUM_PHASES) begin : g_bad_calc_phase
    $error("next_pc_unit: CALC_PHASE must be less than NUM_PHASES");
  end

  logic [PW-1:0]   phase;
  logic            at_calc;
  logic            capture;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] base;
  logic [XLEN-1:0] target_c;
  logic [XLEN-1:0] link_c;
  logic [XLEN-1:0] next_c;
  logic            misaligned_c;
  logic [XLEN-1:0] target_q;
  logic [XLEN-1:0] link_q;
  logic [XLEN-1:0] next_q;
  logic            valid_q;
  logic            misaligned_q;

  phase_counter #(
    .NUM_PHASES (NUM_PHASES),
    .AT_PHASE   (CALC_PHASE),
    .PW         (PW)
  ) u_phase (
    .clock    (clock),
    .reset    (reset),
    .enable   (bus.enable),
    .phase    (phase),
    .at_phase (at_calc)
  );

  assign capture = bus.enable & at_calc;

  // Word-addressed PCs take byte offsets; the arithmetic shift keeps negative offsets exact.
  always_comb begin
    imm_s    = BYTE_ADDR ? bus.imm_in : XLEN'($signed(bus.imm_in) >>> 2);
    base     = (bus.mode_in == MODE_JALR) ? bus.rs1_in : bus.pc_in;
    target_c = base + imm_s;
    if (BYTE_ADDR && (bus.mode_in == MODE_JALR)) begin
      target_c[0] = 1'b0;
    end
    link_c = bus.pc_in + XLEN'(PC_STEP);
    case (bus.mode_in)
      MODE_SEQ:    next_c = link_c;
      MODE_BRANCH: next_c = bus.taken_in ? target_c : link_c;
      default:     next_c = target_c;
    endcase
    misaligned_c = BYTE_ADDR && (next_c[1:0] != 2'b00);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      target_q     <= '0;
      link_q       <= '0;
      next_q       <= '0;
      valid_q      <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      valid_q <= capture;
      if (capture) begin
        target_q     <= target_c;
        link_q       <= link_c;
        next_q       <= next_c;
        misaligned_q <= misaligned_c;
      end
    end
  end

  assign bus.phase_out      = phase;
  assign bus.target_out     = target_q;
  assign bus.link_out       = link_q;
  assign bus.next_pc_out    = next_q;
  assign bus.valid_out      = valid_q;
  assign bus.misaligned_out = misaligned_q;

endmodule

// File: doc/next_pc_unit.md
Name: next_pc_unit

Overview:
Parametrised next-PC / branch-target unit for the multi-cycle datapath. It keeps its own phase counter and, in one configurable phase of each instruction, computes the registered branch/jump target, the link address and the selected next PC. Supported modes are sequential, conditional branch, JAL and JALR. Its outputs feed the PC-source mux and the register-file write-back mux.

Parameters:
XLEN, 32, datapath/PC width in bits
NUM_PHASES, 10, phases per instruction (counter modulus), >=2
CALC_PHASE, 4, phase in which results are captured, 0..NUM_PHASES-1
WORD_ADDR, 1, 1 = PC counts words (immediate arithmetically shifted right by 2); 0 = byte addressing
PC_STEP, 1, sequential increment (set 4 when WORD_ADDR=0)

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
enable  in  1  1 = advance phase/capture; 0 = stall (freeze all state)
pc_in  in  XLEN  current PC
rs1_in  in  XLEN  JALR base register value
imm_in  in  XLEN  sign-extended immediate from the immediate generator
mode_in  in  2  00 SEQ, 01 BRANCH, 10 JAL, 11 JALR
taken_in  in  1  branch condition result (used in BRANCH only)
phase_out  out  $clog2(NUM_PHASES)  current phase
target_out  out  XLEN  registered computed target
link_out  out  XLEN  registered pc_in+PC_STEP (return address)
next_pc_out  out  XLEN  registered selected next PC
valid_out  out  1  one-cycle pulse: outputs updated
misaligned_out  out  1  registered target-misalignment flag

Behaviour:
- Reset (asynchronous, dominates everything): phase, target_out, link_out, next_pc_out = 0; valid_out = 0; misaligned_out = 0.
- Phase counter: on each rising edge with enable=1, phase <= (phase==NUM_PHASES-1) ? 0 : phase+1. The first enabled edge after reset moves phase 0->1. With enable=0 the phase holds.
- Capture: on an edge with enable=1 and phase==CALC_PHASE, capture all results from the current inputs. Between captures all result outputs hold their values.
- Scaled immediate: imm_s = WORD_ADDR ? (imm_in >>> 2) : imm_in. The shift is arithmetic, so negative offsets are exact.
- target: SEQ/BRANCH/JAL = pc_in + imm_s; JALR = rs1_in + imm_s, with bit 0 forced to 0 when WORD_ADDR=0.
- link = pc_in + PC_STEP.
- next_pc: SEQ -> link; BRANCH -> taken_in ? target : link; JAL/JALR -> target.
- All additions are modulo 2^XLEN (wrap), with no carry out.
- misaligned: WORD_ADDR=0 and the selected next_pc has bits [1:0] != 0. It is always 0 when WORD_ADDR=1.
- valid_out: registered. It is 1 for exactly the one cycle after a capture edge (phase reads CALC_PHASE+1 mod NUM_PHASES), else 0. It also goes 0 on the next edge if enable=0 in that cycle.
- Stall: with enable=0 at phase==CALC_PHASE, no capture happens; the capture occurs on the first later edge with enable=1.
- Reset mid-instruction: phase returns to 0 and any pending capture is lost. No valid_out occurs until CALC_PHASE is next reached.
- Latency: capture-edge inputs to valid registered outputs is 1 clock.
- Elaboration check: CALC_PHASE < NUM_PHASES, otherwise $error.

Decomposition:
- Shared package (next_pc_pkg):
  - mode enum (MODE_SEQ=2'b00, MODE_BRANCH=2'b01, MODE_JAL=2'b10, MODE_JALR=2'b11);
  - default XLEN, NUM_PHASES and CALC_PHASE constants, shared with the control unit so both agree on phase numbering.
- Sub-module phase_counter (parameters NUM_PHASES; ports clock, reset, enable, phase, at_phase compare output for CALC_PHASE). The control FSM reuses it.
- Target/select arithmetic stays combinational inside next_pc_unit.

Test Plan:
- Reset then 10 enabled cycles -> phase 0,1..9,0. valid_out high only in the cycle where phase==5. All outputs 0 before the first capture.
- WORD_ADDR=1, pc=100, imm=8, BRANCH, taken=1 at capture -> target=102, link=101, next_pc=102, valid pulse.
- Same stimulus with imm=-8 (32'hFFFFFFF8), taken=0 -> target=98, next_pc=101. Then JALR with rs1=40, imm=-4 -> target=39, next_pc=39.
- pc=32'hFFFFFFFF, SEQ -> link=0, next_pc=0 (wrap, no flag). For WORD_ADDR=0, PC_STEP=4: JAL pc=0x100, imm=0x6 -> next_pc=0x106, misaligned_out=1.
- enable=0 held for 3 cycles while phase==4 -> phase stays 4 and outputs are unchanged. Capture and valid follow the first enabled edge.
- reset asserted asynchronously at phase 3 between edges -> immediate phase=0 and outputs 0. No valid_out until phase next passes 4.
